// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus player / response checker.
package stim_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int ERR_W = 16;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

endpackage

// File: rtl/stim_seq_mem.sv
// Stimulus and expected-response vector stores: one shared write port, two async reads.
// Latency: writes visible the cycle after the strobe; reads are combinational.
module stim_seq_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wstim,
    input  logic [WIDTH-1:0] wexp,
    input  logic [AW-1:0]    stim_addr,
    output logic [WIDTH-1:0] stim_rd,
    input  logic [AW-1:0]    exp_addr,
    output logic [WIDTH-1:0] exp_rd
);

    logic [WIDTH-1:0] stim_mem [DEPTH];
    logic [WIDTH-1:0] exp_mem  [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            stim_mem[waddr] <= wstim;
            exp_mem[waddr]  <= wexp;
        end
    end

    assign stim_rd = stim_mem[stim_addr];
    assign exp_rd  = exp_mem[exp_addr];

endmodule

// File: rtl/stim_seq.sv
// Stimulus player and in-order response checker with outstanding tracking and drain timeout.
// Issue is valid/ready, first word the cycle after start; responses are always accepted.
module stim_seq
    import stim_seq_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 256,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic             clk_p,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [AW-1:0]    load_addr,
    input  logic [WIDTH-1:0] load_stim,
    input  logic [WIDTH-1:0] load_exp,
    input  logic [AW:0]      cfg_len,
    input  logic             cfg_loop,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] data_in,
    output logic             in_valid,
    input  logic             in_ready,
    input  logic [WIDTH-1:0] data_out,
    input  logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             timeout,
    output logic [ERR_W-1:0] err_cnt
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [AW:0] ONE   = (AW+1)'(1);
    localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT - 1);

    state_t           state, state_nx;
    logic [AW:0]      len_q, outst;
    logic             loop_q;
    logic [AW-1:0]    iss_ptr, cmp_ptr;
    logic [ERR_W-1:0] err_q;
    logic [TW-1:0]    idle_cnt;
    logic             tmo_q;
    logic [WIDTH-1:0] stim_rd, exp_rd;

    logic active, issue, resp, spur, mism, err_inc;
    logic iss_last, cmp_last, tmo_hit, start_go;

    stim_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk       (clk_p),
        .wen       (load_en && !active),
        .waddr     (load_addr),
        .wstim     (load_stim),
        .wexp      (load_exp),
        .stim_addr (iss_ptr),
        .stim_rd   (stim_rd),
        .exp_addr  (cmp_ptr),
        .exp_rd    (exp_rd)
    );

    assign active   = (state == RUN) || (state == DRAIN);
    assign in_valid = (state == RUN) && (outst < FULL);
    assign data_in  = in_valid ? stim_rd : '0;
    assign issue    = in_valid && in_ready;
    assign resp     = active && out_valid && (outst != '0);
    // Responses with nothing outstanding, or any response once DONE, are spurious.
    assign spur     = out_valid && ((active && outst == '0) || state == DONE);
    assign mism     = resp && (data_out != exp_rd);
    assign err_inc  = spur || mism;
    assign iss_last = ({1'b0, iss_ptr} == len_q - ONE);
    assign cmp_last = ({1'b0, cmp_ptr} == len_q - ONE);
    assign tmo_hit  = (state == DRAIN) && (outst != '0) && !out_valid && (idle_cnt == IDLE_LAST);
    assign start_go = (state == IDLE || state == DONE) && start && !abort;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (start_go) state_nx = (cfg_len == '0) ? DONE : RUN;
            end
            RUN: begin
                if (abort)                            state_nx = IDLE;
                else if (issue && iss_last && !loop_q) state_nx = DRAIN;
            end
            DRAIN: begin
                if (abort)                     state_nx = IDLE;
                else if (outst == '0 || tmo_hit) state_nx = DONE;
            end
            DONE: begin
                if (abort)         state_nx = IDLE;
                else if (start_go) state_nx = (cfg_len == '0) ? DONE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_p) begin
        if (!rst_n) begin
            state    <= IDLE;
            len_q    <= '0;
            loop_q   <= 1'b0;
            iss_ptr  <= '0;
            cmp_ptr  <= '0;
            outst    <= '0;
            err_q    <= '0;
            idle_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (start_go) begin
                len_q   <= cfg_len;
                loop_q  <= cfg_loop;
                iss_ptr <= '0;
                cmp_ptr <= '0;
                outst   <= '0;
                err_q   <= '0;
                tmo_q   <= 1'b0;
            end else begin
                if (issue) iss_ptr <= iss_last ? '0 : iss_ptr + 1'b1;
                if (resp)  cmp_ptr <= cmp_last ? '0 : cmp_ptr + 1'b1;
                if (issue && !resp)      outst <= outst + ONE;
                else if (!issue && resp) outst <= outst - ONE;
                if (err_inc && err_q != ERR_MAX) err_q <= err_q + 1'b1;
                if (tmo_hit && !abort) tmo_q <= 1'b1;
            end
            if (state != DRAIN || out_valid) idle_cnt <= '0;
            else                             idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign busy    = active;
    assign done    = (state == DONE);
    assign pass    = done && (err_q == '0) && !tmo_q;
    assign timeout = tmo_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_stim_seq.sv
// Bench for stim_seq: an echo responder plus a scoreboard of expected issued words.
module tb_stim_seq;
    localparam int WIDTH = 8, DEPTH = 16, AW = 4, TIMEOUT = 256;

    logic             clk_p = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_en = 1'b0;
    logic [AW-1:0]    load_addr = '0;
    logic [WIDTH-1:0] load_stim = '0, load_exp = '0;
    logic [AW:0]      cfg_len = '0;
    logic             cfg_loop = 1'b0, start = 1'b0, abort = 1'b0;
    logic [WIDTH-1:0] data_in, data_out;
    logic             in_valid, in_ready = 1'b1, out_valid;
    logic             busy, done, pass, timeout;
    logic [15:0]      err_cnt;

    logic             resp_en = 1'b1, model_vld = 1'b0, spur_vld = 1'b0;
    logic [WIDTH-1:0] model_dat = '0, spur_dat = '0;
    logic [WIDTH-1:0] exp_q[$], resp_q[$];
    logic [WIDTH-1:0] stim_v[DEPTH], exp_v[DEPTH];
    int               xfer_cnt = 0;
    int               n_cmp = 0, n_bad = 0;

    assign out_valid = model_vld | spur_vld;
    assign data_out  = model_vld ? model_dat : spur_dat;

    stim_seq #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk_p(clk_p), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .cfg_len(cfg_len), .cfg_loop(cfg_loop),
        .start(start), .abort(abort), .data_in(data_in), .in_valid(in_valid),
        .in_ready(in_ready), .data_out(data_out), .out_valid(out_valid), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .err_cnt(err_cnt)
    );

    always #5 clk_p = ~clk_p;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // Echo responder: every accepted word is returned one cycle later when enabled.
    always @(posedge clk_p) begin
        if (in_valid && in_ready) begin
            xfer_cnt++;
            resp_q.push_back(data_in);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL sb_extra_xfer: got word %0d, expected no transfer", data_in);
            end else begin
                check("sb_data", data_in, exp_q.pop_front());
            end
        end
        #1;
        if (resp_en && resp_q.size() > 0) begin
            model_vld = 1'b1;
            model_dat = resp_q.pop_front();
        end else begin
            model_vld = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk_p);
        #2;
    endtask

    task automatic flush();
        exp_q.delete();
        resp_q.delete();
    endtask

    task automatic load_all();
        for (int i = 0; i < DEPTH; i++) begin
            load_en = 1'b1; load_addr = AW'(i); load_stim = stim_v[i]; load_exp = exp_v[i];
            tick();
        end
        load_en = 1'b0;
    endtask

    task automatic run_start(input int len, input logic lp);
        cfg_len = (AW+1)'(len); cfg_loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cyc);
        cyc = 0;
        while (!done && cyc < bound) begin
            tick();
            cyc++;
        end
    endtask

    task automatic spur_pulse();
        spur_vld = 1'b1; spur_dat = 8'hA5;
        tick();
        spur_vld = 1'b0;
    endtask

    typedef struct {
        int   len;
        int   bad;      // entry whose expected word is corrupted, -1 for none
        int   exp_err;
        logic exp_pass;
    } vec_t;

    vec_t tbl[5];

    initial begin : main
        int cyc, x0;
        logic found;

        tbl[0] = '{3, -1, 0, 1'b1};
        tbl[1] = '{3,  1, 1, 1'b0};
        tbl[2] = '{16, -1, 0, 1'b1};
        tbl[3] = '{1,  0, 1, 1'b0};
        tbl[4] = '{16, 15, 1, 1'b0};
        for (int i = 0; i < DEPTH; i++) begin
            case (i)
                0: stim_v[i] = 8'd8;
                1: stim_v[i] = 8'd2;
                2: stim_v[i] = 8'd5;
                default: stim_v[i] = WIDTH'(7 * i + 3);
            endcase
        end

        tick(); tick();
        check("rst_in_valid", in_valid, 0);
        check("rst_data_in", data_in, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_timeout", timeout, 0);
        check("rst_err", err_cnt, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven one-shot runs with an always-ready echo responder.
        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < DEPTH; i++) exp_v[i] = stim_v[i];
            if (tbl[t].bad >= 0) exp_v[tbl[t].bad] = stim_v[tbl[t].bad] ^ 8'h01;
            load_all();
            flush();
            for (int i = 0; i < tbl[t].len; i++) exp_q.push_back(stim_v[i]);
            run_start(tbl[t].len, 1'b0);
            wait_done(100, cyc);
            check($sformatf("t%0d_done", t), done, 1);
            check($sformatf("t%0d_latency", t), cyc, tbl[t].len + 2);
            check($sformatf("t%0d_err", t), err_cnt, tbl[t].exp_err);
            check($sformatf("t%0d_pass", t), pass, tbl[t].exp_pass);
            check($sformatf("t%0d_timeout", t), timeout, 0);
            check($sformatf("t%0d_sb_left", t), exp_q.size(), 0);
        end

        // Backpressure while word 2 is presented.
        for (int i = 0; i < DEPTH; i++) exp_v[i] = stim_v[i];
        load_all();
        flush();
        for (int i = 0; i < 3; i++) exp_q.push_back(stim_v[i]);
        x0 = xfer_cnt;
        run_start(3, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            if (in_valid && data_in == 8'd2) found = 1'b1;
            else tick();
        end
        check("bp_seen", found, 1);
        in_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("bp_data_held", data_in, 2);
            check("bp_vld_held", in_valid, 1);
        end
        in_ready = 1'b1;
        wait_done(100, cyc);
        check("bp_done", done, 1);
        check("bp_pass", pass, 1);
        check("bp_xfers", xfer_cnt - x0, 3);
        check("bp_sb_left", exp_q.size(), 0);

        // Looped playback: credit limit at DEPTH outstanding, then resume and abort.
        flush();
        for (int k = 0; k < 64; k++) exp_q.push_back(stim_v[k % 4]);
        resp_en = 1'b0;
        x0 = xfer_cnt;
        run_start(4, 1'b1);
        repeat (24) tick();
        check("loop_cap_xfers", xfer_cnt - x0, DEPTH);
        check("loop_cap_vld", in_valid, 0);
        check("loop_cap_busy", busy, 1);
        resp_en = 1'b1;
        cyc = 0;
        while (xfer_cnt - x0 < 40 && cyc < 200) begin
            tick();
            cyc++;
        end
        check("loop_reached_40", (xfer_cnt - x0 >= 40), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_vld", in_valid, 0);
        check("abort_err", err_cnt, 0);
        tick(); tick();
        flush();

        // Drain timeout: responder silent.
        resp_en = 1'b0;
        for (int i = 0; i < 2; i++) exp_q.push_back(stim_v[i]);
        run_start(2, 1'b0);
        wait_done(400, cyc);
        check("tmo_done", done, 1);
        check("tmo_latency", cyc, 2 + TIMEOUT);
        check("tmo_flag", timeout, 1);
        check("tmo_pass", pass, 0);
        check("tmo_err", err_cnt, 0);
        flush();
        resp_en = 1'b1;

        // Spurious responses while DONE.
        spur_pulse();
        check("spur_done_1", err_cnt, 1);
        spur_pulse();
        check("spur_done_2", err_cnt, 2);
        check("spur_done_pass", pass, 0);

        // Spurious responses in RUN with nothing outstanding, then reset mid-run.
        in_ready = 1'b0;
        flush();
        run_start(3, 1'b0);
        check("spur_run_tmo_clr", timeout, 0);
        check("spur_run_err_clr", err_cnt, 0);
        spur_pulse();
        spur_pulse();
        check("spur_run_err", err_cnt, 2);
        check("spur_run_vld", in_valid, 1);
        rst_n = 1'b0;
        tick();
        check("mid_rst_vld", in_valid, 0);
        check("mid_rst_data", data_in, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err_cnt, 0);
        check("mid_rst_tmo", timeout, 0);
        rst_n = 1'b1;
        in_ready = 1'b1;
        tick();

        // Zero-length run completes immediately; abort holds err_cnt.
        flush();
        run_start(0, 1'b0);
        check("len0_done", done, 1);
        check("len0_pass", pass, 1);
        check("len0_busy", busy, 0);
        spur_pulse();
        check("len0_spur_err", err_cnt, 1);
        check("len0_spur_pass", pass, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("len0_abort_done", done, 0);
        check("len0_abort_err_held", err_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
